usb_rw_arbiter: RTL and testbench
=================================

USB_RW_ARBITER -- requirements
Module: usb_rw_arbiter

Interface
REQ-001 Parameter MAX_RETRY, default 2, number of re-issues after a failed transfer before failure is reported.
REQ-002 Parameter TIMEOUT_CYCLES, default 16'd50000, cycles allowed in WAIT before abandoning a transfer attempt.
REQ-003 One clock, reset synchronous active-high; ports: clock  in  1  rising-edge clock; reset  in  1  synchronous active-high reset.
REQ-004 req_valid  in  2  per-requester request pending (index 0, 1).
REQ-005 req_ready  out  2  one-cycle accept pulse to the granted requester.
REQ-006 req_write  in  2  per-requester op: 1 = write, 0 = read.
REQ-007 req_mempage  in  2x16  per-requester memory page.
REQ-008 req_wdata  in  2x64  per-requester write data.
REQ-009 rsp_valid  out  2  response pending to the owning requester; held until rsp_ready.
REQ-010 rsp_ready  in  2  requester consumes response.
REQ-011 rsp_success, rsp_timeout  out  1 each  outcome of the completed request; valid while rsp_valid is non-zero.
REQ-012 rsp_rdata  out  64  read data; valid while rsp_valid is non-zero and the op was a successful read.
REQ-013 read_start, write_start  out  1 each  single-cycle start pulses to the USB read/write sequencer.
REQ-014 read_mempage, write_mempage  out  16 each; write_data  out  64  latched request fields, stable from start pulse to finished.
REQ-015 finished, read_success, write_success  in  1 each; read_data  in  64  sequencer completion status and data.

Function
REQ-016 FSM states: IDLE, ISSUE, WAIT, RESP.
REQ-017 IDLE: if any req_valid is set, grant one requester, pulse its req_ready, latch op, mempage and wdata, clear retry_cnt, and go to ISSUE next cycle.
REQ-018 Arbitration: round-robin; last_grant toggles on each grant; on contention the requester != last_grant wins; a single requester always wins.
REQ-019 ISSUE: exactly one cycle; pulse write_start (write) or read_start (read), load the timeout counter to 0, go to WAIT.
REQ-020 WAIT: increment the timeout counter every cycle; on finished, success = write_success (write) or read_success (read).
REQ-021 WAIT success: capture read_data into rsp_rdata (reads only), rsp_success=1, rsp_timeout=0, go to RESP.
REQ-022 WAIT failure (finished without success): if retry_cnt < MAX_RETRY, increment retry_cnt and go to ISSUE; otherwise rsp_success=0 and go to RESP.
REQ-023 Timeout: counter reaching TIMEOUT_CYCLES-1 without finished sets rsp_timeout=1, rsp_success=0, no retry, go to RESP; finished on that same cycle takes priority over timeout.
REQ-024 RESP: assert rsp_valid bit of the owner only; on rsp_ready of the owner, go to IDLE next cycle; rsp_ready of the other requester is ignored.
REQ-025 Latency: req_ready at cycle T implies a start pulse at T+1; the earliest next grant is the cycle after rsp_ready handshake.
REQ-026 read_start and write_start are never both high; neither is asserted outside ISSUE.
REQ-027 Latched mempage and wdata are unaffected by requester inputs changing after req_ready.
REQ-028 Width rules: retry_cnt width is $clog2(MAX_RETRY+1); timeout counter is 16 bits and never wraps.

Reset
REQ-029 Reset forces IDLE; req_ready, rsp_valid, read_start and write_start are all 0; rsp_success, rsp_timeout, rsp_rdata, retry_cnt, timeout counter and last_grant (=1, so requester 0 wins first contention) are all 0 or as stated.
REQ-030 Reset mid-transfer abandons the request with no response; the sequencer is reset by the same reset.

Structure
REQ-031 Shared package holds the state enum, default MAX_RETRY and TIMEOUT_CYCLES, and requester count constant (2).
REQ-032 One sub-module, usb_rr_picker: combinational 2-way round-robin select (req_valid, last_grant -> grant index, grant valid).

Verification
REQ-033 Read on requester 0, page 16'h1234, sequencer returns finished+read_success with data 64'hDEADBEEF_CAFEF00D -> read_start at T+1, read_mempage=16'h1234, rsp_valid=2'b01, rsp_success=1, rsp_rdata matches.
REQ-034 Both requesters valid in the same cycle after reset, both issued twice -> grant order 0,1,0,1; each response on its own rsp_valid bit only.
REQ-035 Write on requester 1 whose sequencer fails twice, then succeeds -> exactly 3 write_start pulses, rsp_success=1.
REQ-036 Write that fails 3 times with MAX_RETRY=2 -> 3 write_start pulses, then rsp_success=0, rsp_timeout=0.
REQ-037 No finished for TIMEOUT_CYCLES=100 -> rsp_timeout=1 exactly 100 cycles after the start pulse, no re-issue.
REQ-038 Reset asserted in WAIT -> next cycle all outputs at reset values; a new request is then granted normally.

Source files
------------

// File: rtl/usb_rw_arbiter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | usb_rw_arbiter_pkg : shared types and defaults for usb_rw_arbiter  |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
package usb_rw_arbiter_pkg;

    localparam int          NUM_REQ                = 2;
    localparam int          DEFAULT_MAX_RETRY      = 2;
    localparam logic [15:0] DEFAULT_TIMEOUT_CYCLES = 16'd50000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/usb_rr_picker.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | usb_rr_picker : combinational 2-way round-robin requester select   |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
module usb_rr_picker
    import usb_rw_arbiter_pkg::*;
(
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic               last_grant,
    output logic               grant_idx,
    output logic               grant_valid
);

    always_comb begin
        grant_valid = |req_valid;
        // On contention the requester that did not win last time goes next.
        if (&req_valid) begin
            grant_idx = ~last_grant;
        end else begin
            grant_idx = req_valid[1];
        end
    end

endmodule
`default_nettype wire

// File: rtl/usb_rw_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | usb_rw_arbiter : two-requester arbiter in front of a USB read/write |
// | sequencer with retry and timeout.               Revision 1.0       |
// +--------------------------------------------------------------------+
module usb_rw_arbiter
    import usb_rw_arbiter_pkg::*;
#(
    parameter int          MAX_RETRY      = DEFAULT_MAX_RETRY,
    parameter logic [15:0] TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                 clock,
    input  logic                 reset,

    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [NUM_REQ-1:0]   req_write,
    input  logic [NUM_REQ*16-1:0] req_mempage,
    input  logic [NUM_REQ*64-1:0] req_wdata,

    output logic [NUM_REQ-1:0]   rsp_valid,
    input  logic [NUM_REQ-1:0]   rsp_ready,
    output logic                 rsp_success,
    output logic                 rsp_timeout,
    output logic [63:0]          rsp_rdata,

    output logic                 read_start,
    output logic                 write_start,
    output logic [15:0]          read_mempage,
    output logic [15:0]          write_mempage,
    output logic [63:0]          write_data,
    input  logic                 finished,
    input  logic                 read_success,
    input  logic                 write_success,
    input  logic [63:0]          read_data
);

    localparam int                 RETRY_W     = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRY);
    localparam logic [16:0]        TMO_LAST    = {1'b0, TIMEOUT_CYCLES} - 17'd1;

    arb_state_t         state;
    arb_state_t         state_next;

    logic               owner;
    logic               op_write;
    logic [15:0]        mempage;
    logic [63:0]        wdata;
    logic [RETRY_W-1:0] retry_cnt;
    logic [15:0]        tmo_cnt;
    logic               last_grant;

    logic               pick_idx;
    logic               pick_valid;
    logic               grant;
    logic               xfer_ok;
    logic               can_retry;
    logic               timeout_hit;
    logic [15:0]        tmo_inc;
    logic               pick_write;
    logic [15:0]        pick_page;
    logic [63:0]        pick_wdata;

    usb_rr_picker u_picker (
        .req_valid   (req_valid),
        .last_grant  (last_grant),
        .grant_idx   (pick_idx),
        .grant_valid (pick_valid)
    );

    assign pick_write = pick_idx ? req_write[1]          : req_write[0];
    assign pick_page  = pick_idx ? req_mempage[31:16]    : req_mempage[15:0];
    assign pick_wdata = pick_idx ? req_wdata[127:64]     : req_wdata[63:0];

    assign xfer_ok   = op_write ? write_success : read_success;
    assign can_retry = (retry_cnt < RETRY_LIMIT);

    // Saturating count; the timeout fires as the count arrives at its last value.
    assign tmo_inc     = (&tmo_cnt) ? tmo_cnt : tmo_cnt + 16'd1;
    assign timeout_hit = ({1'b0, tmo_inc} >= TMO_LAST);

    assign read_mempage  = mempage;
    assign write_mempage = mempage;
    assign write_data    = wdata;

    assign rsp_valid = (state == ST_RESP) ? (owner ? 2'b10 : 2'b01) : 2'b00;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        req_ready   = '0;
        read_start  = 1'b0;
        write_start = 1'b0;
        grant       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!reset && pick_valid) begin
                    grant               = 1'b1;
                    req_ready[pick_idx] = 1'b1;
                    state_next          = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                write_start = op_write;
                read_start  = ~op_write;
                state_next  = ST_WAIT;
            end
            ST_WAIT: begin
                // A completion on the timeout cycle wins over the timeout.
                if (finished) begin
                    if (xfer_ok || !can_retry) begin
                        state_next = ST_RESP;
                    end else begin
                        state_next = ST_ISSUE;
                    end
                end else if (timeout_hit) begin
                    state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready[owner]) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            owner       <= 1'b0;
            op_write    <= 1'b0;
            mempage     <= '0;
            wdata       <= '0;
            retry_cnt   <= '0;
            tmo_cnt     <= '0;
            last_grant  <= 1'b1;
            rsp_success <= 1'b0;
            rsp_timeout <= 1'b0;
            rsp_rdata   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant) begin
                        owner       <= pick_idx;
                        last_grant  <= pick_idx;
                        op_write    <= pick_write;
                        mempage     <= pick_page;
                        wdata       <= pick_wdata;
                        retry_cnt   <= '0;
                        rsp_success <= 1'b0;
                        rsp_timeout <= 1'b0;
                        rsp_rdata   <= '0;
                    end
                end
                ST_ISSUE: begin
                    tmo_cnt <= '0;
                end
                ST_WAIT: begin
                    tmo_cnt <= tmo_inc;
                    if (finished) begin
                        if (xfer_ok) begin
                            rsp_success <= 1'b1;
                            rsp_timeout <= 1'b0;
                            if (!op_write) begin
                                rsp_rdata <= read_data;
                            end
                        end else if (can_retry) begin
                            retry_cnt <= retry_cnt + RETRY_W'(1);
                        end else begin
                            rsp_success <= 1'b0;
                            rsp_timeout <= 1'b0;
                        end
                    end else if (timeout_hit) begin
                        rsp_success <= 1'b0;
                        rsp_timeout <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_usb_rw_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_usb_rw_arbiter : directed self-checking bench for usb_rw_arbiter |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
module tb_usb_rw_arbiter;

    logic          clock = 1'b0;
    logic          reset;
    logic [1:0]    req_valid;
    logic [1:0]    req_ready;
    logic [1:0]    req_write;
    logic [31:0]   req_mempage;
    logic [127:0]  req_wdata;
    logic [1:0]    rsp_valid;
    logic [1:0]    rsp_ready;
    logic          rsp_success;
    logic          rsp_timeout;
    logic [63:0]   rsp_rdata;
    logic          read_start;
    logic          write_start;
    logic [15:0]   read_mempage;
    logic [15:0]   write_mempage;
    logic [63:0]   write_data;
    logic          finished;
    logic          read_success;
    logic          write_success;
    logic [63:0]   read_data;

    int checks = 0;
    int errors = 0;

    usb_rw_arbiter #(
        .MAX_RETRY      (2),
        .TIMEOUT_CYCLES (16'd100)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_write     (req_write),
        .req_mempage   (req_mempage),
        .req_wdata     (req_wdata),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_success   (rsp_success),
        .rsp_timeout   (rsp_timeout),
        .rsp_rdata     (rsp_rdata),
        .read_start    (read_start),
        .write_start   (write_start),
        .read_mempage  (read_mempage),
        .write_mempage (write_mempage),
        .write_data    (write_data),
        .finished      (finished),
        .read_success  (read_success),
        .write_success (write_success),
        .read_data     (read_data)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          idx;
        bit          wr;
        logic [15:0] page;
        logic [63:0] wdata;
        int          nfail;
        logic [63:0] rdata;
        int          exp_starts;
        bit          exp_succ;
    } vec_t;

    vec_t vecs[5];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    // One request, served by a sequencer model that fails the first nfail attempts.
    task automatic run_txn(input vec_t v);
        int          starts = 0;
        int          cd     = -1;
        bit          ok;
        logic [1:0]  own    = (v.idx == 1) ? 2'b10 : 2'b01;
        logic [1:0]  oth    = (v.idx == 1) ? 2'b01 : 2'b10;

        req_write[v.idx]              = v.wr;
        req_mempage[v.idx*16 +: 16]   = v.page;
        req_wdata[v.idx*64 +: 64]     = v.wdata;
        req_valid[v.idx]              = 1'b1;
        #1;
        for (int k = 0; k < 20; k++) begin
            if (req_ready[v.idx]) break;
            tick();
        end
        check("req_ready", req_ready, own);
        tick();
        req_valid[v.idx] = 1'b0;
        req_write[v.idx] = ~v.wr;
        req_mempage      = $urandom;
        req_wdata        = {$urandom, $urandom, $urandom, $urandom};
        #1;
        check("start_kind", {write_start, read_start}, v.wr ? 2'b10 : 2'b01);
        check("mempage", v.wr ? write_mempage : read_mempage, v.page);
        if (v.wr) check("write_data", write_data, v.wdata);

        for (int cyc = 0; cyc < 300; cyc++) begin
            if (rsp_valid != 2'b00) break;
            check("start_exclusive", read_start & write_start, 1'b0);
            if (read_start || write_start) begin
                starts++;
                cd = 2;
            end
            finished      = 1'b0;
            read_success  = 1'b0;
            write_success = 1'b0;
            if (cd == 0) begin
                ok            = (starts > v.nfail);
                finished      = 1'b1;
                read_success  = v.wr ? 1'b1 : ok;
                write_success = v.wr ? ok : 1'b1;
                read_data     = v.rdata;
                cd            = -1;
                check("mempage_hold", v.wr ? write_mempage : read_mempage, v.page);
            end else if (cd > 0) begin
                cd--;
            end
            tick();
        end
        finished      = 1'b0;
        read_success  = 1'b0;
        write_success = 1'b0;

        check("rsp_valid", rsp_valid, own);
        check("rsp_success", rsp_success, v.exp_succ);
        check("rsp_timeout", rsp_timeout, 1'b0);
        check("start_count", starts, v.exp_starts);
        if (!v.wr && v.exp_succ) check("rsp_rdata", rsp_rdata, v.rdata);

        rsp_ready = oth;
        tick();
        check("rsp_hold_other_ready", rsp_valid, own);
        rsp_ready = own;
        tick();
        rsp_ready = 2'b00;
        #1;
        check("rsp_released", rsp_valid, 2'b00);
    endtask

    initial begin
        int          cnt[2];
        int          got;
        int          n;
        int          restarts;
        vec_t        v;

        vecs[0] = '{0, 1'b0, 16'h1234, 64'h0,                   0, 64'hDEADBEEF_CAFEF00D, 1, 1'b1};
        vecs[1] = '{1, 1'b1, 16'hABCD, 64'h0123_4567_89AB_CDEF, 2, 64'h0,                 3, 1'b1};
        vecs[2] = '{0, 1'b1, 16'h5555, 64'hFEDC_BA98_7654_3210, 3, 64'h0,                 3, 1'b0};
        vecs[3] = '{1, 1'b0, 16'h00FF, 64'h0,                   1, 64'h1111_2222_3333_4444, 2, 1'b1};
        vecs[4] = '{0, 1'b0, 16'h8001, 64'h0,                   3, 64'h9999_9999_9999_9999, 3, 1'b0};

        reset         = 1'b1;
        req_valid     = 2'b00;
        req_write     = 2'b00;
        req_mempage   = '0;
        req_wdata     = '0;
        rsp_ready     = 2'b00;
        finished      = 1'b0;
        read_success  = 1'b0;
        write_success = 1'b0;
        read_data     = '0;
        tick(); tick(); tick();
        check("reset_req_ready", req_ready, 2'b00);
        check("reset_rsp_valid", rsp_valid, 2'b00);
        check("reset_starts", {read_start, write_start}, 2'b00);
        check("reset_rsp_success", rsp_success, 1'b0);
        check("reset_rsp_timeout", rsp_timeout, 1'b0);
        check("reset_rsp_rdata", rsp_rdata, 64'h0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 5; i++) begin
            run_txn(vecs[i]);
        end

        // Contention from reset: both requesters want two transfers each.
        reset = 1'b1;
        tick();
        reset       = 1'b0;
        cnt[0]      = 2;
        cnt[1]      = 2;
        req_write   = 2'b00;
        req_mempage = {16'h0B0B, 16'h0A0A};
        req_valid   = 2'b11;
        #1;
        for (int g = 0; g < 4; g++) begin
            if (g > 0) check("regrant_latency", |req_ready, 1'b1);
            for (int k = 0; k < 20; k++) begin
                if (req_ready != 2'b00) break;
                tick();
            end
            got = req_ready[1] ? 1 : 0;
            check("grant_order", req_ready, (g % 2 == 1) ? 2'b10 : 2'b01);
            cnt[got]--;
            tick();
            if (cnt[got] == 0) req_valid[got] = 1'b0;
            check("contend_start", read_start, 1'b1);
            tick();
            finished     = 1'b1;
            read_success = 1'b1;
            read_data    = 64'h0;
            tick();
            finished     = 1'b0;
            read_success = 1'b0;
            for (int k = 0; k < 20; k++) begin
                if (rsp_valid != 2'b00) break;
                tick();
            end
            check("contend_rsp_owner", rsp_valid, (got == 1) ? 2'b10 : 2'b01);
            rsp_ready = rsp_valid;
            tick();
            rsp_ready = 2'b00;
            #1;
        end

        // Sequencer never finishes: timeout 100 cycles after the start pulse.
        req_write[0]        = 1'b0;
        req_mempage[15:0]   = 16'h7777;
        req_valid[0]        = 1'b1;
        #1;
        for (int k = 0; k < 20; k++) begin
            if (req_ready[0]) break;
            tick();
        end
        tick();
        req_valid = 2'b00;
        check("tmo_start", read_start, 1'b1);
        n        = 0;
        restarts = 0;
        for (int k = 0; k < 200; k++) begin
            tick();
            n++;
            if (read_start || write_start) restarts++;
            if (rsp_valid != 2'b00) break;
        end
        check("tmo_latency", n, 100);
        check("tmo_flag", rsp_timeout, 1'b1);
        check("tmo_success", rsp_success, 1'b0);
        check("tmo_reissue", restarts, 0);
        check("tmo_owner", rsp_valid, 2'b01);
        rsp_ready = 2'b01;
        tick();
        rsp_ready = 2'b00;

        // Reset while waiting on the sequencer abandons the transfer.
        req_write[1]         = 1'b1;
        req_mempage[31:16]   = 16'h4242;
        req_valid[1]         = 1'b1;
        #1;
        for (int k = 0; k < 20; k++) begin
            if (req_ready[1]) break;
            tick();
        end
        tick();
        req_valid = 2'b00;
        check("rst_wait_start", write_start, 1'b1);
        tick(); tick(); tick();
        reset = 1'b1;
        tick();
        check("rst_wait_req_ready", req_ready, 2'b00);
        check("rst_wait_rsp_valid", rsp_valid, 2'b00);
        check("rst_wait_starts", {read_start, write_start}, 2'b00);
        check("rst_wait_flags", {rsp_success, rsp_timeout}, 2'b00);
        check("rst_wait_rdata", rsp_rdata, 64'h0);
        reset = 1'b0;
        tick(); tick();
        check("rst_no_response", rsp_valid, 2'b00);
        v = '{1, 1'b0, 16'h3C3C, 64'h0, 0, 64'hA5A5_5A5A_0F0F_F0F0, 1, 1'b1};
        run_txn(v);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
